// File: rtl/calc_sequencer.sv
// Keypad sequencer for the two-operand decimal arithmetic unit: collects operands
// and operator, pulses the unit enable for a settle window, then captures its total.
module calc_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int RESULT_W      = 14
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          key,
   input  logic                key_valid,
   output logic [5:0]          num000,
   output logic [5:0]          num001,
   output logic [5:0]          num011,
   output logic [5:0]          num100,
   output logic [5:0]          arithmetic,
   output logic                math_enable,
   input  logic [RESULT_W-1:0] math_total,
   output logic [RESULT_W-1:0] result,
   output logic                result_valid,
   output logic                negative,
   output logic                error,
   output logic                busy
);

   typedef enum logic [2:0] {
      A_ENTRY = 3'd0,
      OP_WAIT = 3'd1,
      B_ENTRY = 3'd2,
      CALC    = 3'd3,
      DONE    = 3'd4,
      ERR     = 3'd5
   } state_t;

   localparam logic [5:0] K_CLEAR = 6'd10;
   localparam logic [5:0] K_SUB   = 6'd12;
   localparam logic [5:0] K_DIV   = 6'd14;
   localparam logic [5:0] K_EQ    = 6'd15;
   localparam logic [3:0] LAST    = 4'(SETTLE_CYCLES - 1);

   function automatic logic [6:0] operand_val(input logic [3:0] tens, input logic [3:0] ones);
      return 7'(tens) * 7'd10 + 7'(ones);
   endfunction

   state_t                state_q, state_d;
   logic [3:0]            a_tens_q, a_tens_d, a_ones_q, a_ones_d;
   logic [3:0]            b_tens_q, b_tens_d, b_ones_q, b_ones_d;
   logic [1:0]            a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic [5:0]            op_q, op_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [RESULT_W-1:0]   result_q, result_d;
   logic                  rvld_q, rvld_d, neg_q, neg_d, err_q, err_d;

   logic       is_digit, is_clear, is_op, is_eq;
   logic [6:0] a_val, b_val;

   assign is_digit = key_valid && (key < 6'd10);
   assign is_clear = key_valid && (key == K_CLEAR);
   assign is_op    = key_valid && (key >= 6'd11) && (key <= 6'd14);
   assign is_eq    = key_valid && (key == K_EQ);
   assign a_val    = operand_val(a_tens_q, a_ones_q);
   assign b_val    = operand_val(b_tens_q, b_ones_q);

   always_comb begin
      state_d  = state_q;
      a_tens_d = a_tens_q;
      a_ones_d = a_ones_q;
      b_tens_d = b_tens_q;
      b_ones_d = b_ones_q;
      a_cnt_d  = a_cnt_q;
      b_cnt_d  = b_cnt_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      rvld_d   = rvld_q;
      neg_d    = neg_q;
      err_d    = err_q;

      case (state_q)
         A_ENTRY: begin
            if (is_digit && (a_cnt_q != 2'd2)) begin
               a_tens_d = a_ones_q;
               a_ones_d = key[3:0];
               a_cnt_d  = a_cnt_q + 2'd1;
            end
            if (is_op && (a_cnt_q != 2'd0)) begin
               op_d    = key;
               state_d = B_ENTRY;
            end
         end
         B_ENTRY: begin
            if (is_digit && (b_cnt_q != 2'd2)) begin
               b_tens_d = b_ones_q;
               b_ones_d = key[3:0];
               b_cnt_d  = b_cnt_q + 2'd1;
            end
            if (is_op) begin
               op_d = key;
            end
            if (is_eq && (b_cnt_q != 2'd0)) begin
               if ((op_q == K_DIV) && (b_val == 7'd0)) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end else begin
                  neg_d   = (op_q == K_SUB) && (a_val < b_val);
                  cnt_d   = 4'd0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (cnt_q == LAST) begin
               result_d = math_total;
               rvld_d   = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE, ERR: begin
            // A new digit starts a fresh calculation with that digit as operand A.
            if (is_digit) begin
               a_tens_d = 4'd0;
               a_ones_d = key[3:0];
               a_cnt_d  = 2'd1;
               b_tens_d = 4'd0;
               b_ones_d = 4'd0;
               b_cnt_d  = 2'd0;
               neg_d    = 1'b0;
               rvld_d   = 1'b0;
               err_d    = 1'b0;
               state_d  = A_ENTRY;
            end
         end
         default: state_d = A_ENTRY;
      endcase

      if (is_clear) begin
         a_tens_d = 4'd0;
         a_ones_d = 4'd0;
         b_tens_d = 4'd0;
         b_ones_d = 4'd0;
         a_cnt_d  = 2'd0;
         b_cnt_d  = 2'd0;
         op_d     = 6'd0;
         cnt_d    = 4'd0;
         result_d = '0;
         rvld_d   = 1'b0;
         neg_d    = 1'b0;
         err_d    = 1'b0;
         state_d  = A_ENTRY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= A_ENTRY;
         a_tens_q <= 4'd0;
         a_ones_q <= 4'd0;
         b_tens_q <= 4'd0;
         b_ones_q <= 4'd0;
         a_cnt_q  <= 2'd0;
         b_cnt_q  <= 2'd0;
         op_q     <= 6'd0;
         cnt_q    <= 4'd0;
         result_q <= '0;
         rvld_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_tens_q <= a_tens_d;
         a_ones_q <= a_ones_d;
         b_tens_q <= b_tens_d;
         b_ones_q <= b_ones_d;
         a_cnt_q  <= a_cnt_d;
         b_cnt_q  <= b_cnt_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         rvld_q   <= rvld_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
      end
   end

   assign num000       = {2'b00, a_tens_q};
   assign num001       = {2'b00, a_ones_q};
   assign num011       = {2'b00, b_tens_q};
   assign num100       = {2'b00, b_ones_q};
   assign arithmetic   = op_q;
   assign math_enable  = (state_q == CALC);
   assign busy         = (state_q == CALC);
   assign result       = result_q;
   assign result_valid = rvld_q;
   assign negative     = neg_q;
   assign error        = err_q;

endmodule
